switch_allocator: RTL

- Per-router scheduler that shares the crossbar outputs between rx ports.
- Each rx port raises sw_req with a destination channel (sw_chnl). Per output, the allocator picks one requester round-robin and streams that port's 8-flit packet buffer by driving its buf_addr 0..7.
- It drives the crossbar select and valid, then pulses that rx's sw_gnt on the last flit to release the buffer.

---
 rtl/noc_defs.sv | 20 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/switch_allocator.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/noc_defs.sv
// ---------------------------------------------------------------------------
// noc_defs
// Shared constants and types for the router switch-allocation logic.
//   FLIT_W      : flit payload width in bits
//   CHNL_W      : width of a channel / rx index field
//   PKT_FLITS   : flits per packet (equals the rx buffer depth)
//   out_state_e : per-output scheduler state (ST_IDLE / ST_STREAM)
// ---------------------------------------------------------------------------
package noc_defs;

  localparam int FLIT_W    = 8;
  localparam int CHNL_W    = 3;
  localparam int PKT_FLITS = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } out_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker: returns the first asserted request
// strictly after the pointer position, wrapping around.
// Ports:
//   i_req : request vector, one bit per requester
//   i_ptr : index of the most recently served requester
//   o_gnt : one-hot grant (all zero when nothing is requested)
//   o_idx : index of the granted requester (0 when nothing is requested)
// ---------------------------------------------------------------------------
module rr_arbiter
  import noc_defs::*;
#(
  parameter int N = 5
) (
  input  logic [N-1:0]      i_req,
  input  logic [CHNL_W-1:0] i_ptr,
  output logic [N-1:0]      o_gnt,
  output logic [CHNL_W-1:0] o_idx
);

  always_comb begin
    int  w_cand;
    logic w_found;
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = 0;
    // Scan ptr+1, ptr+2, ... ptr+N so the pointer itself has lowest priority.
    for (int k = 1; k <= N; k++) begin
      w_cand = (int'(i_ptr) + k) % N;
      if (!w_found && i_req[w_cand]) begin
        o_gnt[w_cand] = 1'b1;
        o_idx         = CHNL_W'(w_cand);
        w_found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// ---------------------------------------------------------------------------
// switch_allocator
// Shares the crossbar outputs between the rx ports. Each output runs an
// IDLE/STREAM scheduler: in IDLE it picks one requester round-robin, in
// STREAM it walks that rx's packet buffer address 0..PKT_FLITS-1 and
// releases the buffer with a one-cycle sw_gnt on the last flit.
// Ports:
//   i_clk        : clock
//   i_reset      : synchronous active-high reset
//   i_sw_req     : per-rx request level, held until sw_gnt is seen
//   i_sw_chnl    : per-rx destination output, slice i = [3i+2:3i]
//   o_sw_gnt     : per-rx registered release pulse (last flit)
//   o_buf_addr   : per-rx buffer read address
//   o_out_sel    : per-output crossbar select (rx index)
//   o_out_valid  : per-output flit valid, aligned with the selected buf_addr
//   i_out_ready  : per-output downstream can accept a flit this cycle
// ---------------------------------------------------------------------------
module switch_allocator
  import noc_defs::*;
#(
  parameter int N_IN      = 5,
  parameter int N_OUT     = 5,
  parameter int PKT_FLITS = noc_defs::PKT_FLITS
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [N_IN-1:0]         i_sw_req,
  input  logic [CHNL_W*N_IN-1:0]  i_sw_chnl,
  output logic [N_IN-1:0]         o_sw_gnt,
  output logic [CHNL_W*N_IN-1:0]  o_buf_addr,
  output logic [CHNL_W*N_OUT-1:0] o_out_sel,
  output logic [N_OUT-1:0]        o_out_valid,
  input  logic [N_OUT-1:0]        i_out_ready
);

  localparam int              CNT_W = (PKT_FLITS > 1) ? $clog2(PKT_FLITS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PKT_FLITS - 1);

  // Per-output state
  out_state_e          r_state [N_OUT];
  logic [CHNL_W-1:0]   r_owner [N_OUT];
  logic [CHNL_W-1:0]   r_ptr   [N_OUT];
  logic [CNT_W-1:0]    r_cnt   [N_OUT];
  logic [N_OUT-1:0]    r_out_valid;
  logic [CHNL_W*N_OUT-1:0] r_out_sel;

  // Per-rx state
  logic [N_IN-1:0]         r_sw_gnt;
  logic [N_IN-1:0]         r_gnt_d;    // sw_gnt delayed: blanks an immediate re-grant
  logic [CHNL_W*N_IN-1:0]  r_buf_addr;

  // Next-state / combinational signals
  out_state_e          w_state_next [N_OUT];
  logic [CHNL_W-1:0]   w_owner_next [N_OUT];
  logic [CHNL_W-1:0]   w_ptr_next   [N_OUT];
  logic [CNT_W-1:0]    w_cnt_next   [N_OUT];
  logic [N_OUT-1:0]    w_valid_next;
  logic [N_OUT-1:0]    w_gnt_set;
  logic [N_IN-1:0]     w_gnt_next;
  logic [CHNL_W*N_IN-1:0]  w_addr_next;
  logic [CHNL_W*N_OUT-1:0] w_sel_next;

  logic [N_IN-1:0]     w_owned;
  logic [N_IN-1:0]     w_elig    [N_OUT];
  logic [N_IN-1:0]     w_arb_gnt [N_OUT];
  logic [CHNL_W-1:0]   w_arb_idx [N_OUT];

  assign o_sw_gnt    = r_sw_gnt;
  assign o_buf_addr  = r_buf_addr;
  assign o_out_sel   = r_out_sel;
  assign o_out_valid = r_out_valid;

  // Eligibility. Matching sw_chnl against an output index o < N_OUT also
  // filters out-of-range channels: they match no output, so they are never
  // granted and never occupy an arbiter slot.
  always_comb begin
    w_owned = '0;
    for (int o = 0; o < N_OUT; o++) begin
      for (int i = 0; i < N_IN; i++) begin
        if (r_state[o] == ST_STREAM && r_owner[o] == CHNL_W'(i)) begin
          w_owned[i] = 1'b1;
        end
      end
    end
    for (int o = 0; o < N_OUT; o++) begin
      w_elig[o] = '0;
      for (int i = 0; i < N_IN; i++) begin
        w_elig[o][i] = i_sw_req[i]
                     && (i_sw_chnl[CHNL_W*i +: CHNL_W] == CHNL_W'(o))
                     && !w_owned[i]
                     && !r_gnt_d[i];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_arb
      rr_arbiter #(
        .N (N_IN)
      ) u_arb (
        .i_req (w_elig[gi]),
        .i_ptr (r_ptr[gi]),
        .o_gnt (w_arb_gnt[gi]),
        .o_idx (w_arb_idx[gi])
      );
    end
  endgenerate

  // Per-output FSM next state, then the per-rx and per-output registered
  // outputs derived from it.
  always_comb begin
    w_valid_next = '0;
    w_gnt_set    = '0;
    for (int o = 0; o < N_OUT; o++) begin
      w_state_next[o] = r_state[o];
      w_owner_next[o] = r_owner[o];
      w_ptr_next[o]   = r_ptr[o];
      w_cnt_next[o]   = r_cnt[o];
      case (r_state[o])
        ST_IDLE: begin
          if (|w_arb_gnt[o]) begin
            w_state_next[o] = ST_STREAM;
            w_owner_next[o] = w_arb_idx[o];
            w_ptr_next[o]   = w_arb_idx[o];
            w_cnt_next[o]   = '0;
            w_valid_next[o] = i_out_ready[o];
          end
        end
        ST_STREAM: begin
          // A flit transfers whenever the current valid register is set.
          if (r_out_valid[o] && r_cnt[o] == LAST) begin
            w_state_next[o] = ST_IDLE;
            w_cnt_next[o]   = '0;
            w_valid_next[o] = 1'b0;
          end else begin
            if (r_out_valid[o]) begin
              w_cnt_next[o] = r_cnt[o] + CNT_W'(1);
            end
            w_valid_next[o] = i_out_ready[o];
          end
        end
        default: begin
          w_state_next[o] = ST_IDLE;
        end
      endcase
      // sw_gnt is registered, so raise it one cycle early: exactly when the
      // next cycle will present the last flit with valid high.
      if (w_state_next[o] == ST_STREAM && w_valid_next[o] && w_cnt_next[o] == LAST) begin
        w_gnt_set[o] = 1'b1;
      end
    end

    w_gnt_next  = '0;
    w_addr_next = '0;
    w_sel_next  = '0;
    for (int o = 0; o < N_OUT; o++) begin
      if (w_state_next[o] == ST_STREAM) begin
        w_sel_next[CHNL_W*o +: CHNL_W] = w_owner_next[o];
      end
    end
    for (int i = 0; i < N_IN; i++) begin
      for (int o = 0; o < N_OUT; o++) begin
        if (w_state_next[o] == ST_STREAM && w_owner_next[o] == CHNL_W'(i)) begin
          w_addr_next[CHNL_W*i +: CHNL_W] = CHNL_W'(w_cnt_next[o]);
          if (w_gnt_set[o]) begin
            w_gnt_next[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int o = 0; o < N_OUT; o++) begin
        r_state[o] <= ST_IDLE;
        r_owner[o] <= '0;
        r_ptr[o]   <= CHNL_W'(N_IN - 1);  // rx0 gets first priority
        r_cnt[o]   <= '0;
      end
      r_out_valid <= '0;
      r_out_sel   <= '0;
      r_sw_gnt    <= '0;
      r_gnt_d     <= '0;
      r_buf_addr  <= '0;
    end else begin
      for (int o = 0; o < N_OUT; o++) begin
        r_state[o] <= w_state_next[o];
        r_owner[o] <= w_owner_next[o];
        r_ptr[o]   <= w_ptr_next[o];
        r_cnt[o]   <= w_cnt_next[o];
      end
      r_out_valid <= w_valid_next;
      r_out_sel   <= w_sel_next;
      r_sw_gnt    <= w_gnt_next;
      r_gnt_d     <= r_sw_gnt;
      r_buf_addr  <= w_addr_next;
    end
  end

endmodule
